// File: rtl/pb_pkg.sv
// Shared types and constants for the protobuf varint field encoder.
// Wire-type and FSM encodings plus varint size limits.
package pb_pkg;

    typedef enum logic [2:0] {
        WT_VARINT = 3'd0,
        WT_I64    = 3'd1,
        WT_LEN    = 3'd2,
        WT_SGROUP = 3'd3,
        WT_EGROUP = 3'd4,
        WT_I32    = 3'd5
    } pb_wtype_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        VAL  = 2'd2
    } pb_state_e;

    localparam int PB_MAX_VARINT_BYTES = 10;
    localparam int PB_TAG_W            = 32;

endpackage

// File: rtl/pb_varint_step.sv
// One base-128 varint step: low 7 bits plus continuation flag, remainder shifted down.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the step.
module pb_varint_step (
    input  logic [63:0] rem,
    output logic [7:0]  step_byte,
    output logic [63:0] rem_next,
    output logic        last
);

    assign last      = (rem[63:7] == '0);
    assign step_byte = {~last, rem[6:0]};
    assign rem_next  = rem >> 7;

endmodule

// File: rtl/pb_field_encoder.sv
// Serializes one protobuf varint field (tag then value) per accepted descriptor.
// Latency: first tag byte one cycle after accept, then one byte per cycle.
// Backpressure: out_ready low freezes the output byte and all state; in_ready only in IDLE.
module pb_field_encoder
    import pb_pkg::*;
#(
    parameter int FIELD_W = 29,
    parameter int VAL_W   = 64
) (
    input  logic               PCLK,
    input  logic               PRESERN,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FIELD_W-1:0] in_field,
    input  logic [2:0]         in_wtype,
    input  logic [VAL_W-1:0]   in_value,
    input  logic               in_zigzag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_byte,
    output logic               out_last,
    output logic               err,
    output logic               busy
);

    pb_state_e           state;
    logic [PB_TAG_W-1:0] tag_rem;
    logic [63:0]         val_rem;

    logic [PB_TAG_W-1:0] tag_in;
    logic [VAL_W-1:0]    val_map;
    logic                bad_desc;
    logic                out_hs;

    logic [63:0]         step_in;
    logic [7:0]          step_byte;
    logic [63:0]         step_next;
    logic                step_last;

    assign tag_in   = PB_TAG_W'({in_field, 3'b000});
    assign val_map  = in_zigzag ? ((in_value << 1) ^ {VAL_W{in_value[VAL_W-1]}}) : in_value;
    assign bad_desc = (pb_wtype_e'(in_wtype) != WT_VARINT) || (in_field == '0);
    assign out_hs   = out_valid && out_ready;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // The byte on the output carries its own continuation bit, so it tells us
    // whether the next step comes from the tag remainder or starts the value.
    always_comb begin
        step_in = val_rem;
        case (state)
            IDLE:    step_in = 64'(tag_in);
            TAG:     step_in = out_byte[7] ? 64'(tag_rem) : val_rem;
            default: step_in = val_rem;
        endcase
    end

    pb_varint_step u_step (
        .rem       (step_in),
        .step_byte (step_byte),
        .rem_next  (step_next),
        .last      (step_last)
    );

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state     <= IDLE;
            tag_rem   <= '0;
            val_rem   <= '0;
            out_valid <= 1'b0;
            out_byte  <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (bad_desc) begin
                            err <= 1'b1;
                        end else begin
                            out_valid <= 1'b1;
                            out_byte  <= step_byte;
                            out_last  <= 1'b0;
                            tag_rem   <= step_next[PB_TAG_W-1:0];
                            val_rem   <= 64'(val_map);
                            state     <= TAG;
                        end
                    end
                end
                TAG: begin
                    if (out_hs) begin
                        out_byte <= step_byte;
                        if (out_byte[7]) begin
                            out_last <= 1'b0;
                            tag_rem  <= step_next[PB_TAG_W-1:0];
                        end else begin
                            out_last <= step_last;
                            val_rem  <= step_next;
                            state    <= VAL;
                        end
                    end
                end
                VAL: begin
                    if (out_hs) begin
                        if (out_byte[7]) begin
                            out_byte <= step_byte;
                            out_last <= step_last;
                            val_rem  <= step_next;
                        end else begin
                            out_valid <= 1'b0;
                            out_byte  <= '0;
                            out_last  <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pb_field_encoder.md
Name: pb_field_encoder

Overview:
Serializes one protobuf varint field (tag plus value) per transaction into a byte stream.
- Sits directly downstream of the APB3 peripheral top level. The APB register logic captures the CPU-written field number, wire type and 64-bit value, then hands them over on the in_* valid/ready interface.
- Emits base-128 varint bytes LSB-group first on the out_* valid/ready interface, toward the output byte buffer.
- Supports wire type 0 (varint) only, with optional zigzag mapping for sint64.

Parameters:
- FIELD_W, 29, width of the protobuf field number (protobuf maximum is 2^29-1).
- VAL_W, 64, width of the value operand. The value varint is at most ceil(VAL_W/7) bytes; 10 at the default.

Ports:
- PCLK  input  1  clock
- PRESERN  input  1  reset, asynchronous, active-low
- in_valid  input  1  field descriptor valid
- in_ready  output  1  encoder can accept a descriptor
- in_field  input  FIELD_W  field number
- in_wtype  input  3  wire type
- in_value  input  VAL_W  value, two's complement when in_zigzag=1
- in_zigzag  input  1  apply zigzag mapping (sint64)
- out_valid  output  1  out_byte valid
- out_ready  input  1  consumer accepts byte
- out_byte  output  8  encoded byte
- out_last  output  1  final byte of the field (last value byte)
- err  output  1  one-cycle pulse: descriptor rejected
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset (PRESERN low, asynchronous): state=IDLE, out_valid=0, out_byte=0, out_last=0, err=0, busy=0, all internal registers 0. in_ready=1 once reset is released. Reset asserted mid-field aborts the field: no further bytes, no out_last.
- Accept: handshake when in_valid && in_ready. in_ready=1 only in IDLE.
- Validation at accept:
  - If in_wtype!=0 or in_field==0: err=1 for exactly the next cycle, nothing is emitted, state stays IDLE, in_ready stays 1.
  - Otherwise latch the tag and the value, then go to TAG.
- Tag = {in_field, 3'b000}, zero-extended to 32 bits; 1..5 bytes.
- Value = in_zigzag ? ((v<<1) ^ {VAL_W{v[VAL_W-1]}}) : v.
- Byte generation (same rule for tag and value):
  - byte = {rem[63:7]!=0, rem[6:0]}, then rem = rem>>7.
  - A group of zero always produces exactly one byte (0x00).
- FSM:
  - IDLE -> TAG on a valid accept.
  - TAG: emit tag bytes. On the handshake of the tag byte with continuation=0, go to VAL.
  - VAL: emit value bytes. On the handshake of the byte with continuation=0, assert out_last with that byte and return to IDLE.
- Output register:
  - out_valid/out_byte/out_last are registered.
  - The first tag byte is valid in cycle N+1 after the accept in cycle N.
  - While out_valid && !out_ready, out_byte and out_last hold stable and nothing advances.
  - With out_ready=1 continuously: one byte per cycle, no bubble between the tag and value phases.
- in_ready reasserts in the cycle after the last-byte handshake.
- Minimum cycles per field = total bytes + 1.
- busy = (state!=IDLE).
- in_* inputs are ignored while in_ready=0.
- Simultaneous events: in_valid during the last-byte handshake is not accepted; it waits until in_ready=1.

Decomposition:
- Package pb_pkg:
  - wire-type enum: WT_VARINT=0, WT_I64=1, WT_LEN=2, WT_SGROUP=3, WT_EGROUP=4, WT_I32=5.
  - FSM enum: IDLE, TAG, VAL.
  - constants: PB_MAX_VARINT_BYTES=10, PB_TAG_W=32.
- Sub-module pb_varint_step:
  - combinational; takes a 64-bit remaining value and returns the byte, the next remaining value and a last flag.
  - instantiated once and muxed between the tag and value registers.

Test Plan:
- Field 1, value 150, zigzag 0, out_ready=1 -> bytes 08 96 01; out_last only on 01; in_ready high 4 cycles after accept.
- Field 1, value 0 -> 08 00. Field 2, value -1, zigzag 1 -> 10 01. Field 2, value 1, zigzag 1 -> 10 02.
- Field 1, value 64'hFFFF_FFFF_FFFF_FFFF -> 08, FF x9, 01 (11 bytes); out_last on 01.
- Field 2^29-1, value 1 -> F8 FF FF FF 0F 01.
- Field 1, value 300 with out_ready low for 3 cycles on each byte -> bytes 08 AC 02; each byte held stable while stalled; no duplicates or drops.
- wtype=2 -> err pulses 1 cycle, no out_valid, in_ready stays 1. field=0 -> same response. Assert PRESERN low after the second byte of a 10-byte value -> out_valid=0 immediately; in_ready=1 after release; the next field encodes correctly.
